mips_id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 5-stage MIPS core. It captures the decoded control word (MemRead, MemWrite, MemtoReg, RegWrite, RegDst, ALUSrc, Branch, ALUOp) from the ID-stage control unit, together with register operands, the immediate, the register specifiers and PC+4, and presents them registered to EX. It contains load-use hazard detection that freezes PC and IF/ID and injects a bubble. Branch flushes also zero the control word.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/mips_load_use_detector.sv | 26 ++
 rtl/mips_id_ex_stage.sv | 169 ++++++++++++++++
 tb/tb_mips_id_ex_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS pipeline: ALUOp encodings, primary
// opcode constants, and the packed control word carried from ID into EX.
package mips_pkg;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // 9-bit control word produced by the ID-stage control unit
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_word_t;

  // All-zero word: no memory access, no register write, no branch
  localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/mips_load_use_detector.sv
// mips_load_use_detector
// Purely combinational load-use hazard detection between a load sitting in
// EX and the instruction in ID.
// Ports:
//   mem_read_ex_i  load in EX
//   rt_ex_i        destination register of the EX load
//   rs_id_i/rt_id_i source registers of the ID instruction
//   flush_id_i     ID instruction is being squashed (no stall needed)
//   hazard_o       1 = insert a bubble and freeze PC / IF-ID
module mips_load_use_detector #(
  parameter int REG_AW = 5
) (
  input  logic              mem_read_ex_i,
  input  logic [REG_AW-1:0] rt_ex_i,
  input  logic [REG_AW-1:0] rs_id_i,
  input  logic [REG_AW-1:0] rt_id_i,
  input  logic              flush_id_i,
  output logic              hazard_o
);

  // $0 is never a real dependency because writes to it are discarded
  assign hazard_o = mem_read_ex_i & (rt_ex_i != '0) &
                    ((rt_ex_i == rs_id_i) | (rt_ex_i == rt_id_i)) &
                    ~flush_id_i;

endmodule

// File: rtl/mips_id_ex_stage.sv
// mips_id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS core. Registers the decoded
// control word, operands, immediate, register specifiers and PC+4 for EX.
// A branch flush or a load-use bubble zeroes the control word.
// Optional feature macro: MIPS_LOAD_USE_STALL_EN enables load-use hazard
// detection, PC / IF-ID freeze and the saturating stall counter. Without it
// PCWriteEn = IFIDWriteEn = 1 and StallCount = 0.
// Ports:
//   clk, reset                 clock, async active-high reset
//   *ID                        control word and data from ID
//   FlushID                    squash the ID instruction
//   *EX                        registered copies for EX
//   PCWriteEn, IFIDWriteEn     0 = hold PC / IF-ID this cycle
//   StallCount                 saturating count of load-use bubbles
module mips_id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemReadID,
  input  logic                   MemwriteID,
  input  logic                   MemtoregID,
  input  logic                   RegWriteID,
  input  logic                   RegDstID,
  input  logic                   ALUsrcID,
  input  logic                   BranchID,
  input  logic [1:0]             ALUOPID,
  input  logic [DATA_W-1:0]      ReadData1ID,
  input  logic [DATA_W-1:0]      ReadData2ID,
  input  logic [DATA_W-1:0]      SignExtID,
  input  logic [DATA_W-1:0]      PCPlus4ID,
  input  logic [REG_AW-1:0]      RsID,
  input  logic [REG_AW-1:0]      RtID,
  input  logic [REG_AW-1:0]      RdID,
  input  logic [5:0]             FunctID,
  input  logic                   FlushID,
  output logic                   MemReadEX,
  output logic                   MemwriteEX,
  output logic                   MemtoregEX,
  output logic                   RegWriteEX,
  output logic                   RegDstEX,
  output logic                   ALUsrcEX,
  output logic                   BranchEX,
  output logic [1:0]             ALUOPEX,
  output logic [DATA_W-1:0]      ReadData1EX,
  output logic [DATA_W-1:0]      ReadData2EX,
  output logic [DATA_W-1:0]      SignExtEX,
  output logic [DATA_W-1:0]      PCPlus4EX,
  output logic [REG_AW-1:0]      RsEX,
  output logic [REG_AW-1:0]      RtEX,
  output logic [REG_AW-1:0]      RdEX,
  output logic [5:0]             FunctEX,
  output logic                   PCWriteEn,
  output logic                   IFIDWriteEn,
  output logic [STALL_CNT_W-1:0] StallCount
);

  ctrl_word_t        ctrl_id;
  ctrl_word_t        ctrl_d, ctrl_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, sext_q, pc4_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [5:0]        funct_q;
  logic              hazard;

  always_comb begin
    ctrl_id            = CTRL_NOP;
    ctrl_id.mem_read   = MemReadID;
    ctrl_id.mem_write  = MemwriteID;
    ctrl_id.mem_to_reg = MemtoregID;
    ctrl_id.reg_write  = RegWriteID;
    ctrl_id.reg_dst    = RegDstID;
    ctrl_id.alu_src    = ALUsrcID;
    ctrl_id.branch     = BranchID;
    ctrl_id.alu_op     = ALUOPID;
  end

`ifdef MIPS_LOAD_USE_STALL_EN
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  mips_load_use_detector #(
    .REG_AW (REG_AW)
  ) u_load_use_detector (
    .mem_read_ex_i (ctrl_q.mem_read),
    .rt_ex_i       (rt_q),
    .rs_id_i       (RsID),
    .rt_id_i       (RtID),
    .flush_id_i    (FlushID),
    .hazard_o      (hazard)
  );

  // Saturate at all-ones; a wrap would make a long stall look short
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
`else
  assign hazard     = 1'b0;
  assign StallCount = '0;
`endif

  // Flush already masks the hazard, so either one alone yields a NOP word
  always_comb begin
    ctrl_d = ctrl_id;
    if (FlushID || hazard) begin
      ctrl_d = CTRL_NOP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= CTRL_NOP;
      rd1_q   <= '0;
      rd2_q   <= '0;
      sext_q  <= '0;
      pc4_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      funct_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      rd1_q   <= ReadData1ID;
      rd2_q   <= ReadData2ID;
      sext_q  <= SignExtID;
      pc4_q   <= PCPlus4ID;
      rs_q    <= RsID;
      rt_q    <= RtID;
      rd_q    <= RdID;
      funct_q <= FunctID;
    end
  end

  assign PCWriteEn   = ~hazard;
  assign IFIDWriteEn = ~hazard;

  assign MemReadEX   = ctrl_q.mem_read;
  assign MemwriteEX  = ctrl_q.mem_write;
  assign MemtoregEX  = ctrl_q.mem_to_reg;
  assign RegWriteEX  = ctrl_q.reg_write;
  assign RegDstEX    = ctrl_q.reg_dst;
  assign ALUsrcEX    = ctrl_q.alu_src;
  assign BranchEX    = ctrl_q.branch;
  assign ALUOPEX     = ctrl_q.alu_op;
  assign ReadData1EX = rd1_q;
  assign ReadData2EX = rd2_q;
  assign SignExtEX   = sext_q;
  assign PCPlus4EX   = pc4_q;
  assign RsEX        = rs_q;
  assign RtEX        = rt_q;
  assign RdEX        = rd_q;
  assign FunctEX     = funct_q;

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Bench for mips_id_ex_stage: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a rule-level model.
module tb_mips_id_ex_stage;

`ifdef MIPS_LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic MemReadID = 0, MemwriteID = 0, MemtoregID = 0, RegWriteID = 0;
  logic RegDstID = 0, ALUsrcID = 0, BranchID = 0, FlushID = 0;
  logic [1:0] ALUOPID = 0;
  logic [31:0] ReadData1ID = 0, ReadData2ID = 0, SignExtID = 0, PCPlus4ID = 0;
  logic [4:0] RsID = 0, RtID = 0, RdID = 0;
  logic [5:0] FunctID = 0;

  logic MemReadEX, MemwriteEX, MemtoregEX, RegWriteEX, RegDstEX, ALUsrcEX, BranchEX;
  logic [1:0] ALUOPEX;
  logic [31:0] ReadData1EX, ReadData2EX, SignExtEX, PCPlus4EX;
  logic [4:0] RsEX, RtEX, RdEX;
  logic [5:0] FunctEX;
  logic PCWriteEn, IFIDWriteEn;
  logic [CW-1:0] StallCount;

  mips_id_ex_stage #(.DATA_W(32), .REG_AW(5), .STALL_CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .MemReadID(MemReadID), .MemwriteID(MemwriteID), .MemtoregID(MemtoregID),
    .RegWriteID(RegWriteID), .RegDstID(RegDstID), .ALUsrcID(ALUsrcID),
    .BranchID(BranchID), .ALUOPID(ALUOPID),
    .ReadData1ID(ReadData1ID), .ReadData2ID(ReadData2ID), .SignExtID(SignExtID),
    .PCPlus4ID(PCPlus4ID), .RsID(RsID), .RtID(RtID), .RdID(RdID),
    .FunctID(FunctID), .FlushID(FlushID),
    .MemReadEX(MemReadEX), .MemwriteEX(MemwriteEX), .MemtoregEX(MemtoregEX),
    .RegWriteEX(RegWriteEX), .RegDstEX(RegDstEX), .ALUsrcEX(ALUsrcEX),
    .BranchEX(BranchEX), .ALUOPEX(ALUOPEX),
    .ReadData1EX(ReadData1EX), .ReadData2EX(ReadData2EX), .SignExtEX(SignExtEX),
    .PCPlus4EX(PCPlus4EX), .RsEX(RsEX), .RtEX(RtEX), .RdEX(RdEX),
    .FunctEX(FunctEX), .PCWriteEn(PCWriteEn), .IFIDWriteEn(IFIDWriteEn),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control word as {MemRead,MemWrite,MemtoReg,RegWrite,RegDst,ALUSrc,Branch,ALUOp}
  function automatic logic [8:0] ctrl_in();
    return {MemReadID, MemwriteID, MemtoregID, RegWriteID, RegDstID, ALUsrcID,
            BranchID, ALUOPID};
  endfunction

  function automatic logic [8:0] ctrl_out();
    return {MemReadEX, MemwriteEX, MemtoregEX, RegWriteEX, RegDstEX, ALUsrcEX,
            BranchEX, ALUOPEX};
  endfunction

  // Reference model: what EX must hold, derived from the stage rules
  logic [8:0]  m_ctrl;
  logic [31:0] m_rd1, m_rd2, m_sext, m_pc4;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [5:0]  m_funct;
  int          m_cnt;

  function automatic bit model_hazard();
    if (!STALL_EN) return 1'b0;
    return m_ctrl[8] && (m_rt != 5'd0) && (m_rt == RsID || m_rt == RtID) && !FlushID;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_sext = 0; m_pc4 = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_funct = 0; m_cnt = 0;
    end else begin
      bit hz;
      hz = model_hazard();
      if (hz && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_ctrl  = (FlushID || hz) ? 9'd0 : ctrl_in();
      m_rd1   = ReadData1ID;
      m_rd2   = ReadData2ID;
      m_sext  = SignExtID;
      m_pc4   = PCPlus4ID;
      m_rs    = RsID;
      m_rt    = RtID;
      m_rd    = RdID;
      m_funct = FunctID;
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_ctrl", ctrl_out(), m_ctrl);
      check("m_rd1", ReadData1EX, m_rd1);
      check("m_rd2", ReadData2EX, m_rd2);
      check("m_sext", SignExtEX, m_sext);
      check("m_pc4", PCPlus4EX, m_pc4);
      check("m_spec", {RsEX, RtEX, RdEX, FunctEX}, {m_rs, m_rt, m_rd, m_funct});
      check("m_pcwe", PCWriteEn, !model_hazard());
      check("m_ifidwe", IFIDWriteEn, !model_hazard());
      check("m_cnt", StallCount, m_cnt[CW-1:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ctrl(input logic [8:0] c);
    {MemReadID, MemwriteID, MemtoregID, RegWriteID, RegDstID, ALUsrcID,
     BranchID, ALUOPID} = c;
  endtask

  localparam logic [8:0] C_LW  = 9'b1_0_1_1_0_1_0_00;
  localparam logic [8:0] C_ADD = 9'b0_0_0_1_1_0_0_10;

  task automatic do_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    #12 reset = 1'b0;
    cmp_en = 1;

    // Reset asserted mid-cycle clears EX immediately
    step();
    set_ctrl(C_ADD);
    step();
    check("pre_reset_regwrite", RegWriteEX, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("reset_ctrl", ctrl_out(), 9'd0);
    check("reset_cnt", StallCount, 0);
    check("reset_pcwe", PCWriteEn, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0;

    // R-type passthrough
    step();
    set_ctrl(C_ADD);
    ReadData1ID = 32'h0000_0005;
    RsID = 5'd1; RtID = 5'd2; RdID = 5'd3;
    #1 check("rtype_pcwe_id", PCWriteEn, 1'b1);
    step();
    check("rtype_regwrite", RegWriteEX, 1'b1);
    check("rtype_aluop", ALUOPEX, 2'b10);
    check("rtype_rd1", ReadData1EX, 32'h5);
    check("rtype_pcwe_ex", PCWriteEn, 1'b1);

    // Load-use stall
    set_ctrl(C_LW); RsID = 5'd1; RtID = 5'd8;
    step();
    set_ctrl(C_ADD); RsID = 5'd8; RtID = 5'd9; RdID = 5'd10;
    #1;
    check("lu_pcwe", PCWriteEn, STALL_EN ? 1'b0 : 1'b1);
    check("lu_ifidwe", IFIDWriteEn, STALL_EN ? 1'b0 : 1'b1);
    step();
    check("lu_bubble", ctrl_out(), STALL_EN ? 9'd0 : C_ADD);
    check("lu_cnt", StallCount, STALL_EN ? 1 : 0);
    check("lu_release", PCWriteEn, 1'b1);
    step();
    check("lu_add_enters", ctrl_out(), C_ADD);
    exp_cnt = STALL_EN ? 1 : 0;

    // $0 exemption
    set_ctrl(C_LW); RsID = 5'd1; RtID = 5'd0;
    step();
    set_ctrl(C_ADD); RsID = 5'd0; RtID = 5'd0;
    #1 check("zero_pcwe", PCWriteEn, 1'b1);
    step();
    check("zero_ctrl", ctrl_out(), C_ADD);
    check("zero_cnt", StallCount, exp_cnt);

    // Flush wins over a simultaneous hazard
    set_ctrl(C_LW); RsID = 5'd1; RtID = 5'd8;
    step();
    set_ctrl(C_ADD); RsID = 5'd8; RtID = 5'd9; FlushID = 1'b1;
    #1 check("flush_pcwe", PCWriteEn, 1'b1);
    step();
    FlushID = 1'b0;
    check("flush_ctrl", ctrl_out(), 9'd0);
    check("flush_cnt", StallCount, exp_cnt);
    check("flush_data", RsEX, 5'd8);

    // Counter saturation over five load-use pairs
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_ctrl(C_LW); RsID = 5'd2; RtID = 5'd7;
      step();
      set_ctrl(C_ADD); RsID = 5'd7; RtID = 5'd3;
      step();
      set_ctrl(9'd0); RsID = 5'd0; RtID = 5'd0;
      check("sat_cnt", StallCount, STALL_EN ? ((i + 1 > 3) ? 3 : i + 1) : 0);
    end

    // Randomized traffic, occasionally interrupted by reset
    for (int i = 0; i < 1500; i++) begin
      set_ctrl(9'($urandom));
      MemReadID   = ($urandom % 2) == 0;
      ReadData1ID = $urandom;
      ReadData2ID = $urandom;
      SignExtID   = $urandom;
      PCPlus4ID   = $urandom;
      RsID        = 5'($urandom_range(0, 3));
      RtID        = 5'($urandom_range(0, 3));
      RdID        = 5'($urandom);
      FunctID     = 6'($urandom);
      FlushID     = ($urandom % 8) == 0;
      if (($urandom % 64) == 0) do_reset();
      step();
    end

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
